// File: rtl/bht_bimodal_update.sv
// Bimodal branch history table: 2-bit saturating counters trained on resolved branches.
// Optional build macro BHT_UPDATE_FWD_EN forwards a same-cycle, same-index update into the prediction.
module bht_bimodal_update #(
    parameter int unsigned NR_ENTRIES   = 1024,
    parameter int unsigned VLEN         = 39,
    parameter int unsigned INSTR_OFFSET = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_bp_i,
    input  logic            debug_mode_i,
    input  logic            lookup_valid_i,
    input  logic [VLEN-1:0] lookup_pc_i,
    output logic            pred_valid_o,
    output logic            pred_taken_o,
    output logic            ready_o,
    input  logic            res_valid_i,
    input  logic [VLEN-1:0] res_pc_i,
    input  logic            res_is_branch_i,
    input  logic            res_taken_i,
    input  logic            res_mispredict_i,
    output logic [31:0]     mispredict_cnt_o
);

    localparam int unsigned IW = $clog2(NR_ENTRIES);

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    state_e        state_q;
    logic [IW-1:0] init_ptr_q;
    logic          ready_q;
    logic          pred_valid_q;
    logic          pred_taken_q;
    logic [31:0]   mispredict_cnt_q;
    logic [1:0]    ctr_q [NR_ENTRIES];

    logic [IW-1:0] lookup_idx;
    logic [IW-1:0] res_idx;
    logic          run;
    logic          train_en;
    logic          lookup_en;
    logic [1:0]    res_ctr;
    logic [1:0]    res_ctr_next;
    logic [1:0]    lookup_ctr;
    logic          unused_pc_bits;

    assign lookup_idx     = lookup_pc_i[INSTR_OFFSET +: IW];
    assign res_idx        = res_pc_i[INSTR_OFFSET +: IW];
    assign unused_pc_bits = ^{lookup_pc_i, res_pc_i};

    assign run      = (state_q == RUN);
    assign train_en = run && res_valid_i && res_is_branch_i && !debug_mode_i && !flush_bp_i;

    // Lookup has no back-pressure: a lookup accepted in RUN yields pred_valid_o exactly one
    // cycle later; lookups presented while ready_o is low (or during a flush) are dropped.
    assign lookup_en = run && lookup_valid_i && !flush_bp_i;

    assign res_ctr = ctr_q[res_idx];

    always_comb begin
        res_ctr_next = res_ctr;
        if (res_taken_i) begin
            if (res_ctr != 2'b11) res_ctr_next = res_ctr + 2'd1;
        end else begin
            if (res_ctr != 2'b00) res_ctr_next = res_ctr - 2'd1;
        end
    end

    always_comb begin
        lookup_ctr = ctr_q[lookup_idx];
`ifdef BHT_UPDATE_FWD_EN
        if (train_en && (res_idx == lookup_idx)) lookup_ctr = res_ctr_next;
`endif
    end

    // Counter storage carries no reset; the init sweep defines its contents.
    always_ff @(posedge clk_i) begin
        if (!flush_bp_i) begin
            if (state_q == INIT) begin
                ctr_q[init_ptr_q] <= 2'b01;
            end else if (train_en) begin
                ctr_q[res_idx] <= res_ctr_next;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
            ready_q    <= 1'b0;
        end else if (flush_bp_i) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    init_ptr_q <= init_ptr_q + 1'b1;
                    if (init_ptr_q == IW'(NR_ENTRIES - 1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= INIT;
                    init_ptr_q <= '0;
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            pred_valid_q <= lookup_en;
            pred_taken_q <= lookup_en ? lookup_ctr[1] : 1'b0;
        end
    end

    // Statistics survive flushes; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mispredict_cnt_q <= '0;
        end else if (train_en && res_mispredict_i) begin
            mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
        end
    end

    assign ready_o          = ready_q;
    assign pred_valid_o     = pred_valid_q;
    assign pred_taken_o     = pred_taken_q;
    assign mispredict_cnt_o = mispredict_cnt_q;

endmodule
